// File: rtl/buf_exchange_hub_pkg.sv
// -----------------------------------------------------------------------------
// buf_exchange_hub_pkg
// Shared types and constants for the buffer-exchange hub.
//   hub_state_t  : barrier FSM states (COLLECT, RELEASE)
//   ADDR_W       : width of a per-core lookup address
//   SLOT_IDX_*   : address field holding the slot (core) index, bits [4:1]
//   VAL_SEL_BIT  : address bit choosing value 1 (0) or value 2 (1)
//   EPOCH_W      : width of the completed-barrier counter
//   WDOG_W       : width of the optional watchdog counter
// -----------------------------------------------------------------------------
package buf_exchange_hub_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        RELEASE = 1'b1
    } hub_state_t;

    localparam int ADDR_W       = 5;
    localparam int SLOT_IDX_MSB = 4;
    localparam int SLOT_IDX_LSB = 1;
    localparam int SLOT_IDX_W   = SLOT_IDX_MSB - SLOT_IDX_LSB + 1;
    localparam int VAL_SEL_BIT  = 0;
    localparam int EPOCH_W      = 8;
    localparam int WDOG_W       = 16;

    function automatic logic [SLOT_IDX_W-1:0] slot_index(input logic [ADDR_W-1:0] addr);
        return addr[SLOT_IDX_MSB:SLOT_IDX_LSB];
    endfunction

endpackage

// File: rtl/buf_exchange_hub_lookup.sv
// -----------------------------------------------------------------------------
// buf_slot_lookup
// Combinational lookup into the hub slot table. The address picks a slot
// (bits [4:1]) and which of the two stored values to return (bit 0).
// Slots beyond NUM_CORES-1 read as zero.
// Ports:
//   table_val_1 : in  NUM_CORES*DATA_W  stored value 1 of every slot, packed
//   table_val_2 : in  NUM_CORES*DATA_W  stored value 2 of every slot, packed
//   addr        : in  ADDR_W            lookup address
//   data        : out DATA_W            selected value
// -----------------------------------------------------------------------------
module buf_slot_lookup
    import buf_exchange_hub_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 32
) (
    input  logic [NUM_CORES*DATA_W-1:0] table_val_1,
    input  logic [NUM_CORES*DATA_W-1:0] table_val_2,
    input  logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           data
);

    logic [SLOT_IDX_W-1:0] slot_idx;
    logic                  val_sel;

    assign slot_idx = slot_index(addr);
    assign val_sel  = addr[VAL_SEL_BIT];

    // Unmatched indices fall through to the zero default.
    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (slot_idx == SLOT_IDX_W'(k)) begin
                data = val_sel ? table_val_2[k*DATA_W +: DATA_W]
                               : table_val_1[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/buf_exchange_hub.sv
// -----------------------------------------------------------------------------
// buf_exchange_hub
// Inter-core responder for the per-core buffer-exchange interface. Each core
// publishes a value pair with a flag; the hub snapshots the pair once per
// barrier round into a slot table and answers 5-bit address lookups from that
// table with zero latency. all_buf_flags rises one cycle after every core has
// been captured and falls one cycle after every core has withdrawn its flag.
//
// Optional build macro: BUF_XHUB_TIMEOUT_EN adds a watchdog that sets the
// sticky timeout_err when a partially captured round stalls for
// TIMEOUT_CYCLES cycles. Without it timeout_err is constant 0.
//
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   buf_val_1/2       : in  NUM_CORES*DATA_W  published values, core i at [i*DATA_W +: DATA_W]
//   buf_flag          : in  NUM_CORES         publish flag per core
//   buf_val_1/2_addr  : in  NUM_CORES*5       lookup addresses per core
//   buf_val_1/2_select: out NUM_CORES*DATA_W  lookup results per core
//   all_buf_flags     : out 1                 barrier complete
//   epoch             : out 8                 completed barrier count (mod 256)
//   timeout_err       : out 1                 sticky watchdog error
// -----------------------------------------------------------------------------
module buf_exchange_hub
    import buf_exchange_hub_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_CORES*DATA_W-1:0] buf_val_1,
    input  logic [NUM_CORES*DATA_W-1:0] buf_val_2,
    input  logic [NUM_CORES-1:0]        buf_flag,
    input  logic [NUM_CORES*ADDR_W-1:0] buf_val_1_addr,
    input  logic [NUM_CORES*ADDR_W-1:0] buf_val_2_addr,
    output logic [NUM_CORES*DATA_W-1:0] buf_val_1_select,
    output logic [NUM_CORES*DATA_W-1:0] buf_val_2_select,
    output logic                        all_buf_flags,
    output logic [EPOCH_W-1:0]          epoch,
    output logic                        timeout_err
);

    hub_state_t             state_reg, state_next;
    logic [NUM_CORES-1:0]   captured_reg, captured_next;
    logic [NUM_CORES-1:0]   capture_en;
    logic                   all_flags_reg, all_flags_next;
    logic [EPOCH_W-1:0]     epoch_reg, epoch_next;

    logic [NUM_CORES*DATA_W-1:0] table_val_1;
    logic [NUM_CORES*DATA_W-1:0] table_val_2;

    // ------------------------------------------------------------------
    // Barrier FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= COLLECT;
            captured_reg  <= '0;
            all_flags_reg <= 1'b0;
            epoch_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            captured_reg  <= captured_next;
            all_flags_reg <= all_flags_next;
            epoch_reg     <= epoch_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        captured_next  = captured_reg;
        all_flags_next = all_flags_reg;
        epoch_next     = epoch_reg;
        capture_en     = '0;
        case (state_reg)
            COLLECT: begin
                // Only first rise of a flag in this round snapshots the slot.
                capture_en    = buf_flag & ~captured_reg;
                captured_next = captured_reg | capture_en;
                if (&captured_next) begin
                    state_next     = RELEASE;
                    all_flags_next = 1'b1;
                end
            end
            RELEASE: begin
                all_flags_next = 1'b1;
                if (buf_flag == '0) begin
                    captured_next  = '0;
                    all_flags_next = 1'b0;
                    epoch_next     = epoch_reg + EPOCH_W'(1);
                    state_next     = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    assign all_buf_flags = all_flags_reg;
    assign epoch         = epoch_reg;

    // ------------------------------------------------------------------
    // Slot table and per-core lookups
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
        logic [DATA_W-1:0] val_1_reg;
        logic [DATA_W-1:0] val_2_reg;

        always_ff @(posedge Clk) begin
            if (Reset) begin
                val_1_reg <= '0;
                val_2_reg <= '0;
            end else if (capture_en[gi]) begin
                val_1_reg <= buf_val_1[gi*DATA_W +: DATA_W];
                val_2_reg <= buf_val_2[gi*DATA_W +: DATA_W];
            end
        end

        assign table_val_1[gi*DATA_W +: DATA_W] = val_1_reg;
        assign table_val_2[gi*DATA_W +: DATA_W] = val_2_reg;

        buf_slot_lookup #(
            .NUM_CORES (NUM_CORES),
            .DATA_W    (DATA_W)
        ) u_lookup_1 (
            .table_val_1 (table_val_1),
            .table_val_2 (table_val_2),
            .addr        (buf_val_1_addr[gi*ADDR_W +: ADDR_W]),
            .data        (buf_val_1_select[gi*DATA_W +: DATA_W])
        );

        buf_slot_lookup #(
            .NUM_CORES (NUM_CORES),
            .DATA_W    (DATA_W)
        ) u_lookup_2 (
            .table_val_1 (table_val_1),
            .table_val_2 (table_val_2),
            .addr        (buf_val_2_addr[gi*ADDR_W +: ADDR_W]),
            .data        (buf_val_2_select[gi*DATA_W +: DATA_W])
        );
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef BUF_XHUB_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
    logic              timeout_err_reg;
    logic              wdog_run;

    // Runs only while a round is partially captured.
    assign wdog_run = (state_reg == COLLECT) && (|captured_reg) && !(&captured_reg);

    always_comb begin
        wdog_cnt_next = wdog_cnt_reg;
        if ((|capture_en) || (state_next == RELEASE)) begin
            wdog_cnt_next = '0;
        end else if (wdog_run && (wdog_cnt_reg != WDOG_LIMIT)) begin
            // Saturates at the limit so the count never wraps.
            wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wdog_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_next;
            if (wdog_run && (wdog_cnt_next == WDOG_LIMIT)) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic [WDOG_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = WDOG_W'(TIMEOUT_CYCLES);
    assign timeout_err        = 1'b0;
`endif

endmodule
